// File: rtl/count_en_gen.sv
// Programmable enable-pulse generator: divides clk by (div+1) and emits one-cycle
// en pulses, either continuously or for a fixed-length burst, under start/stop control.
module count_en_gen #(
  parameter int DIV_W   = 8,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DIV_W-1:0]   div,
  input  logic [BURST_W-1:0] burst_len,
  output logic               en,
  output logic               busy,
  output logic               done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [DIV_W-1:0]   PC_ONE = DIV_W'(1);
  localparam logic [BURST_W-1:0] BC_ONE = BURST_W'(1);

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   pc_q, pc_d;
  logic [BURST_W-1:0] bc_q, bc_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BURST_W-1:0] len_q, len_d;
  logic               mode_q, mode_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BURST_W-1:0] bc_inc;

  assign bc_inc = bc_q + BC_ONE;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    bc_d    = bc_q;
    div_d   = div_q;
    len_d   = len_q;
    mode_d  = mode_q;
    en_d    = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          div_d  = div;
          len_d  = burst_len;
          mode_d = mode;
          pc_d   = '0;
          bc_d   = '0;
          // A zero-length burst completes immediately without ever entering RUN.
          if (mode && (burst_len == '0)) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (pc_q == div_q) begin
          pc_d = '0;
          en_d = 1'b1;
          if (mode_q) begin
            bc_d = bc_inc;
            if (bc_inc == len_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end else begin
          pc_d = pc_q + PC_ONE;
        end
      end

      default: state_d = IDLE;
    endcase

    // busy tracks the state being entered so it drops together with the last pulse.
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      bc_q    <= '0;
      div_q   <= '0;
      len_q   <= '0;
      mode_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bc_q    <= bc_d;
      div_q   <= div_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign en   = en_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
